// File: rtl/xy_tracker_pkg.sv
// Shared types and helpers for the joystick position tracker.
// Provides the per-axis FSM state, the decoded stick direction, the
// 2-bit stick decoder and the auto-repeat timer width calculation.
package xy_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } axis_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } dir_t;

    // 01 = increment, 10 = decrement; 00 and 11 both mean no movement.
    function automatic dir_t decode_dir(input logic [1:0] stick);
        case (stick)
            2'b01:   return INC;
            2'b10:   return DEC;
            default: return NONE;
        endcase
    endfunction

    // Timer must hold max(delay, rate) - 1; never narrower than one bit.
    function automatic int timer_bits(input int unsigned delay, input int unsigned rate);
        int unsigned m;
        int          b;
        m = (delay > rate) ? delay : rate;
        b = $clog2(m + 1);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/xy_axis_stepper.sv
// One joystick axis: direction FSM with auto-repeat timer and position register.
// Ports:
//   CLK, RST     clock, asynchronous active-low reset
//   home         synchronous load of HOME_VAL, forces IDLE
//   stick        2-bit direction request (bit0 = +1, bit1 = -1)
//   position     current position, registered
//   stepDone_c   combinational: position changes on the coming edge
module xy_axis_stepper
    import xy_tracker_pkg::*;
#(
    parameter int unsigned BITS         = 3,
    parameter int unsigned MAX          = 7,
    parameter int unsigned HOME_VAL     = 0,
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter int unsigned WRAP         = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            home,
    input  logic [1:0]      stick,
    output logic [BITS-1:0] position,
    output logic            stepDone_c
);

    localparam int unsigned TIMER_W = unsigned'(timer_bits(REPEAT_DELAY, REPEAT_RATE));
    localparam int unsigned EXT_W   = BITS + 1;

    localparam logic [TIMER_W-1:0] DELAY_LOAD = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] RATE_LOAD  = TIMER_W'(REPEAT_RATE - 1);
    localparam logic [EXT_W-1:0]   MAX_EXT    = EXT_W'(MAX);
    localparam logic [BITS-1:0]    MAX_POS    = BITS'(MAX);
    localparam logic [BITS-1:0]    HOME_POS   = BITS'(HOME_VAL);

    axis_state_t        state, stateNext;
    dir_t               heldDir, heldDirNext;
    dir_t               dir;
    logic [TIMER_W-1:0] timer, timerNext;
    logic [BITS-1:0]    posNext;
    logic [BITS-1:0]    stepped;
    logic [EXT_W-1:0]   posExt;
    logic               stepReq;

    assign dir    = decode_dir(stick);
    assign posExt = {1'b0, position};

    // Candidate position one step in the requested direction; the extra bit
    // keeps the MAX compare exact for non-power-of-two ranges.
    always_comb begin
        stepped = position;
        if (dir == INC) begin
            if (posExt + EXT_W'(1) > MAX_EXT) begin
                stepped = (WRAP != 0) ? '0 : position;
            end else begin
                stepped = BITS'(posExt + EXT_W'(1));
            end
        end else if (dir == DEC) begin
            if (posExt == '0) begin
                stepped = (WRAP != 0) ? MAX_POS : position;
            end else begin
                stepped = BITS'(posExt - EXT_W'(1));
            end
        end
    end

    // Next state, timer and position; home overrides everything.
    always_comb begin
        stateNext   = state;
        timerNext   = timer;
        heldDirNext = heldDir;
        stepReq     = 1'b0;
        posNext     = position;

        case (state)
            IDLE: begin
                if (dir != NONE) begin
                    stepReq     = 1'b1;
                    timerNext   = DELAY_LOAD;
                    heldDirNext = dir;
                    stateNext   = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (dir == NONE) begin
                    stateNext   = IDLE;
                    timerNext   = '0;
                    heldDirNext = NONE;
                end else if (dir != heldDir) begin
                    // reversal restarts the press sequence in the new direction
                    stepReq     = 1'b1;
                    timerNext   = DELAY_LOAD;
                    heldDirNext = dir;
                    stateNext   = DELAY;
                end else if (timer != '0) begin
                    timerNext = timer - TIMER_W'(1);
                end else begin
                    stepReq   = 1'b1;
                    timerNext = RATE_LOAD;
                    stateNext = REPEAT;
                end
            end
            default: begin
                stateNext   = IDLE;
                timerNext   = '0;
                heldDirNext = NONE;
            end
        endcase

        if (stepReq) begin
            posNext = stepped;
        end

        if (home) begin
            stateNext   = IDLE;
            timerNext   = '0;
            heldDirNext = NONE;
            posNext     = HOME_POS;
        end

        stepDone_c = (posNext != position);
    end

    // State, timer and position registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            heldDir  <= NONE;
            timer    <= '0;
            position <= HOME_POS;
        end else begin
            state    <= stateNext;
            heldDir  <= heldDirNext;
            timer    <= timerNext;
            position <= posNext;
        end
    end

endmodule

// File: rtl/xy_tracker_param.sv
// Joystick dot tracker: two independent axis steppers on a configurable grid.
// Optional build macro XY_TRACKER_SYNC_EN adds 2-flop synchronisers on
// stickX, stickY and HOME (adds 2 cycles of latency).
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   HOME            synchronous recentre to X_HOME/Y_HOME
//   stickX, stickY  bit0 = +1, bit1 = -1 per axis
//   pixelX, pixelY  current position, registered
//   moved           registered pulse: position changed on the previous edge
//   atEdge          combinational: position lies on any border of the grid
module xy_tracker_param
    import xy_tracker_pkg::*;
#(
    parameter int unsigned X_BITS       = 3,
    parameter int unsigned Y_BITS       = 3,
    parameter int unsigned X_MAX        = 7,
    parameter int unsigned Y_MAX        = 7,
    parameter int unsigned X_HOME       = 0,
    parameter int unsigned Y_HOME       = 0,
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter int unsigned WRAP         = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HOME,
    input  logic [1:0]        stickX,
    input  logic [1:0]        stickY,
    output logic [X_BITS-1:0] pixelX,
    output logic [Y_BITS-1:0] pixelY,
    output logic              moved,
    output logic              atEdge
);

    logic       homeIn;
    logic [1:0] stickXIn;
    logic [1:0] stickYIn;
    logic       stepX_c;
    logic       stepY_c;

`ifdef XY_TRACKER_SYNC_EN
    logic       homeMeta;
    logic [1:0] stickXMeta;
    logic [1:0] stickYMeta;

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            homeMeta   <= 1'b0;
            homeIn     <= 1'b0;
            stickXMeta <= 2'b00;
            stickXIn   <= 2'b00;
            stickYMeta <= 2'b00;
            stickYIn   <= 2'b00;
        end else begin
            homeMeta   <= HOME;
            homeIn     <= homeMeta;
            stickXMeta <= stickX;
            stickXIn   <= stickXMeta;
            stickYMeta <= stickY;
            stickYIn   <= stickYMeta;
        end
    end
`else
    assign homeIn   = HOME;
    assign stickXIn = stickX;
    assign stickYIn = stickY;
`endif

    xy_axis_stepper #(
        .BITS         (X_BITS),
        .MAX          (X_MAX),
        .HOME_VAL     (X_HOME),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .WRAP         (WRAP)
    ) xAxis (
        .CLK        (CLK),
        .RST        (RST),
        .home       (homeIn),
        .stick      (stickXIn),
        .position   (pixelX),
        .stepDone_c (stepX_c)
    );

    xy_axis_stepper #(
        .BITS         (Y_BITS),
        .MAX          (Y_MAX),
        .HOME_VAL     (Y_HOME),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .WRAP         (WRAP)
    ) yAxis (
        .CLK        (CLK),
        .RST        (RST),
        .home       (homeIn),
        .stick      (stickYIn),
        .position   (pixelY),
        .stepDone_c (stepY_c)
    );

    // One pulse for any change, even when both axes move on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            moved <= 1'b0;
        end else begin
            moved <= stepX_c | stepY_c;
        end
    end

    assign atEdge = (pixelX == '0) || (pixelX == X_BITS'(X_MAX)) ||
                    (pixelY == '0) || (pixelY == Y_BITS'(Y_MAX));

endmodule

// File: tb/tb_xy_tracker_param.sv
// Self-checking bench: two configurations (saturating, and wrapping with
// non-power-of-two limits and non-zero home) driven by the same stimulus.
module tb_xy_tracker_param;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       HOME = 1'b0;
    logic [1:0] stickX = 2'b00;
    logic [1:0] stickY = 2'b00;
    logic [2:0] pxA, pyA, pxB, pyB;
    logic       movedA, edgeA, movedB, edgeB;

    always #5 CLK = ~CLK;

    xy_tracker_param #(
        .X_BITS(3), .Y_BITS(3), .X_MAX(5), .Y_MAX(7), .X_HOME(0), .Y_HOME(0),
        .REPEAT_DELAY(8), .REPEAT_RATE(4), .WRAP(0)
    ) dutA (
        .CLK(CLK), .RST(RST), .HOME(HOME), .stickX(stickX), .stickY(stickY),
        .pixelX(pxA), .pixelY(pyA), .moved(movedA), .atEdge(edgeA)
    );

    xy_tracker_param #(
        .X_BITS(3), .Y_BITS(3), .X_MAX(5), .Y_MAX(6), .X_HOME(2), .Y_HOME(3),
        .REPEAT_DELAY(3), .REPEAT_RATE(2), .WRAP(1)
    ) dutB (
        .CLK(CLK), .RST(RST), .HOME(HOME), .stickX(stickX), .stickY(stickY),
        .pixelX(pxB), .pixelY(pyB), .moved(movedB), .atEdge(edgeB)
    );

    // Reference configuration: [dut][axis], axis 0 = X, 1 = Y.
    int cfgMax [2][2] = '{'{5, 7}, '{5, 6}};
    int cfgHome[2][2] = '{'{0, 0}, '{2, 3}};
    int cfgD   [2]    = '{8, 3};
    int cfgR   [2]    = '{4, 2};
    int cfgWrap[2]    = '{0, 1};

    // Reference state: position, direction being held (0 none, 1 inc, 2 dec),
    // and edges since the press/reversal that started the current hold.
    int mPos [2][2];
    int mPrev[2][2];
    int mCnt [2][2];
    int mMoved[2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decodeStick(input logic [1:0] s);
        if (s == 2'b01) return 1;
        if (s == 2'b10) return 2;
        return 0;
    endfunction

    function automatic int moveOne(input int p, input int dir, input int mx, input int wrap);
        if (dir == 1) begin
            if (wrap != 0) return (p + 1) % (mx + 1);
            return (p < mx) ? p + 1 : p;
        end
        if (wrap != 0) return (p + mx) % (mx + 1);
        return (p > 0) ? p - 1 : p;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 2; a++) begin
                mPos[d][a]  = cfgHome[d][a];
                mPrev[d][a] = 0;
                mCnt[d][a]  = 0;
            end
            mMoved[d] = 0;
        end
    endtask

    // Predict the state just after the next rising edge from current inputs.
    task automatic modelEdge();
        for (int d = 0; d < 2; d++) begin
            int changed;
            changed = 0;
            for (int a = 0; a < 2; a++) begin
                int dir, old, doStep;
                dir    = decodeStick((a == 0) ? stickX : stickY);
                old    = mPos[d][a];
                doStep = 0;
                if (HOME) begin
                    mPos[d][a]  = cfgHome[d][a];
                    mPrev[d][a] = 0;
                    mCnt[d][a]  = 0;
                end else if (dir == 0) begin
                    mPrev[d][a] = 0;
                    mCnt[d][a]  = 0;
                end else begin
                    if (dir != mPrev[d][a]) begin
                        mPrev[d][a] = dir;
                        mCnt[d][a]  = 0;
                        doStep      = 1;
                    end else begin
                        mCnt[d][a]++;
                        if (mCnt[d][a] >= cfgD[d] && (mCnt[d][a] - cfgD[d]) % cfgR[d] == 0)
                            doStep = 1;
                    end
                    if (doStep != 0)
                        mPos[d][a] = moveOne(mPos[d][a], dir, cfgMax[d][a], cfgWrap[d]);
                end
                if (mPos[d][a] != old) changed = 1;
            end
            mMoved[d] = changed;
        end
    endtask

    function automatic int expEdge(input int d);
        return (mPos[d][0] == 0 || mPos[d][0] == cfgMax[d][0] ||
                mPos[d][1] == 0 || mPos[d][1] == cfgMax[d][1]) ? 1 : 0;
    endfunction

    task automatic checkAll(input string tag);
        chk({tag, ".A.pixelX"}, int'(pxA), mPos[0][0]);
        chk({tag, ".A.pixelY"}, int'(pyA), mPos[0][1]);
        chk({tag, ".A.moved"},  int'(movedA), mMoved[0]);
        chk({tag, ".A.atEdge"}, int'(edgeA), expEdge(0));
        chk({tag, ".B.pixelX"}, int'(pxB), mPos[1][0]);
        chk({tag, ".B.pixelY"}, int'(pyB), mPos[1][1]);
        chk({tag, ".B.moved"},  int'(movedB), mMoved[1]);
        chk({tag, ".B.atEdge"}, int'(edgeB), expEdge(1));
    endtask

    // Drive inputs, advance one edge, compare both DUTs with the model.
    task automatic cycle(input logic h, input logic [1:0] sx, input logic [1:0] sy, input string tag);
        HOME   = h;
        stickX = sx;
        stickY = sy;
        modelEdge();
        @(posedge CLK);
        #1;
        checkAll(tag);
    endtask

    typedef struct {
        logic [1:0] sx;
        int         expX;
        int         expMoved;
    } vec_t;

    vec_t tbl[20];
    int   holdX [20] = '{1,1,1,1,1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4};
    int   holdMv[20] = '{1,0,0,0,0,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0};

    initial begin
        logic [1:0] rsx, rsy;
        int         pulses;

        for (int i = 0; i < 20; i++) begin
            tbl[i].sx       = 2'b01;
            tbl[i].expX     = holdX[i];
            tbl[i].expMoved = holdMv[i];
        end

        // Reset state
        modelReset();
        #12;
        checkAll("reset");
        RST = 1'b1;

        // Idle stick: nothing moves
        for (int i = 0; i < 20; i++) cycle(1'b0, 2'b00, 2'b00, "idle");
        chk("idle.A.pixelX", int'(pxA), 0);
        chk("idle.B.pixelY", int'(pyB), 3);

        // Held +X: steps at edges 0, 8, 12, 16
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 2'b00, 2'b00, "dummy") ;
        end
        modelReset(); // model already at home after idle cycles
        pulses = 0;
        // restore model from DUT-independent knowledge: all idle since reset
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, tbl[i].sx, 2'b00, "hold");
            chk("hold.A.x", int'(pxA), tbl[i].expX);
            chk("hold.A.moved", int'(movedA), tbl[i].expMoved);
            if (movedA) pulses++;
        end
        chk("hold.A.pulses", pulses, 4);

        // Keep holding: reaches X_MAX=5, then saturates with no pulse
        for (int i = 0; i < 8; i++) cycle(1'b0, 2'b01, 2'b00, "sat");
        chk("sat.A.x", int'(pxA), 5);
        chk("sat.A.atEdge", int'(edgeA), 1);
        chk("sat.A.moved", int'(movedA), 0);

        // Recentre
        cycle(1'b0, 2'b00, 2'b00, "rel");
        cycle(1'b1, 2'b00, 2'b00, "home");
        chk("home.A.x", int'(pxA), 0);
        chk("home.B.x", int'(pxB), 2);
        cycle(1'b0, 2'b00, 2'b00, "rel");

        // Reversal: +X for 3 edges, then -X
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b01, 2'b00, "rev+");
        chk("rev.A.x1", int'(pxA), 1);
        cycle(1'b0, 2'b10, 2'b00, "rev-");
        chk("rev.A.x0", int'(pxA), 0);
        chk("rev.B.x", int'(pxB), 2);
        for (int i = 0; i < 9; i++) cycle(1'b0, 2'b10, 2'b00, "rev-");
        cycle(1'b0, 2'b00, 2'b00, "rel");

        // Both Y bits set: no movement
        for (int i = 0; i < 30; i++) cycle(1'b0, 2'b00, 2'b11, "y11");

        // Walk A to (3,2) with taps, then HOME with sticks held
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'b01, 2'b00, "tapx");
            cycle(1'b0, 2'b00, 2'b00, "tapx");
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 2'b00, 2'b01, "tapy");
            cycle(1'b0, 2'b00, 2'b00, "tapy");
        end
        chk("walk.A.x", int'(pxA), 3);
        chk("walk.A.y", int'(pyA), 2);
        cycle(1'b1, 2'b01, 2'b01, "homeHeld");
        chk("homeHeld.A.x", int'(pxA), 0);
        chk("homeHeld.A.moved", int'(movedA), 1);
        cycle(1'b1, 2'b01, 2'b01, "homeHeld2");
        chk("homeHeld2.A.moved", int'(movedA), 0);
        cycle(1'b0, 2'b01, 2'b01, "homeFall");
        chk("homeFall.A.x", int'(pxA), 1);
        chk("homeFall.A.y", int'(pyA), 1);
        cycle(1'b0, 2'b00, 2'b00, "rel");

        // Asynchronous reset in the middle of DELAY
        cycle(1'b0, 2'b01, 2'b00, "preRst");
        cycle(1'b0, 2'b01, 2'b00, "preRst");
        #3;
        RST = 1'b0;
        modelReset();
        #1;
        checkAll("asyncRst");
        #1;
        RST = 1'b1;
        cycle(1'b0, 2'b01, 2'b00, "postRst");
        chk("postRst.A.x", int'(pxA), 1);
        chk("postRst.B.x", int'(pxB), 3);

        // Randomised run with held-biased sticks and rare HOME
        rsx = 2'b00;
        rsy = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) rsx = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) rsy = 2'($urandom_range(0, 3));
            cycle(($urandom_range(0, 39) == 0), rsx, rsy, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xy_tracker_param.md
Name: xy_tracker_param

Overview:
Parametrised successor to the joystick dot tracker. Converts two 2-bit joystick direction inputs into an X/Y pixel position on a configurable WIDTH x HEIGHT grid.
- Press steps immediately; held press auto-repeats after a programmable delay and rate.
- Edge mode per build: saturate or wrap.
- Adds home/recentre input and a move-strobe output.
- Sits between the board joystick inputs and the dot-matrix display driver.

Parameters:
X_BITS, 3, width of pixelX
Y_BITS, 3, width of pixelY
X_MAX, 7, largest legal X (≤ 2^X_BITS-1)
Y_MAX, 7, largest legal Y (≤ 2^Y_BITS-1)
X_HOME, 0, X after reset/HOME (≤ X_MAX)
Y_HOME, 0, Y after reset/HOME (≤ Y_MAX)
REPEAT_DELAY, 8, cycles from initial step to first auto-repeat (≥ 1)
REPEAT_RATE, 4, cycles between subsequent auto-repeats (≥ 1)
WRAP, 0, 0 = saturate at edges, 1 = wrap modulo (MAX+1)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
HOME  in  1  synchronous: load X_HOME/Y_HOME
stickX  in  2  bit0 = increment X, bit1 = decrement X
stickY  in  2  bit0 = increment Y, bit1 = decrement Y
pixelX  out  X_BITS  current X, registered
pixelY  out  Y_BITS  current Y, registered
moved  out  1  one-cycle pulse: position changed on the previous edge
atEdge  out  1  combinational: pixelX ∈ {0,X_MAX} or pixelY ∈ {0,Y_MAX}

Behaviour:
- Reset (RST=0, async):
  - pixelX=X_HOME, pixelY=Y_HOME, moved=0.
  - Both axis FSMs go to IDLE; timers=0.
- Direction decode per axis:
  - 01 = +1, 10 = -1.
  - 00 and 11 = NONE.
- Axis FSM (independent, identical per axis): IDLE, DELAY, REPEAT.
  - IDLE, dir≠NONE: step on this edge; timer ← REPEAT_DELAY-1; go DELAY.
  - DELAY, dir NONE: go IDLE.
  - DELAY, same dir:
    - timer>0: decrement.
    - timer==0: step; timer ← REPEAT_RATE-1; go REPEAT.
  - REPEAT, same dir: same as DELAY, reloading REPEAT_RATE-1 and staying in REPEAT.
  - DELAY/REPEAT, dir reverses: step in new direction on that edge; timer ← REPEAT_DELAY-1; go DELAY.
- Step timing:
  - Steps occur at edges 0, D, D+R, D+2R, … where edge 0 is the first sampled press (D = REPEAT_DELAY, R = REPEAT_RATE).
  - Latency is 1 cycle: output updates on the sampling edge.
- Edge arithmetic uses an (n+1)-bit compare, never native overflow.
  - WRAP=0: +1 at MAX or -1 at 0 leaves the position unchanged; no moved pulse; FSM timing continues.
  - WRAP=1: MAX+1 → 0; 0-1 → MAX. Correct for non-power-of-two MAX.
- HOME=1:
  - Loads both home positions; overrides any step on that edge.
  - Forces both FSMs to IDLE.
  - moved=1 next cycle only if the position actually changed.
  - A stick still held when HOME falls steps on the next edge.
- Simultaneous X and Y steps on one edge: both apply; a single moved pulse.
- Inputs are synchronous to CLK; debouncing is the board wrapper's job.

Optional Feature:
Macro XY_TRACKER_SYNC_EN.
- Defined: stickX, stickY and HOME each pass through a 2-flop synchroniser, reset to 0 by RST. All response latencies grow by 2 cycles.
- Undefined: inputs feed the FSM/decoders directly; latencies as stated above.

Decomposition:
- Package xy_tracker_pkg:
  - axis_state_t enum (IDLE, DELAY, REPEAT).
  - dir_t enum (NONE, INC, DEC).
  - function decode_dir(2-bit) → dir_t.
  - Function for timer width: clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- Sub-module xy_axis_stepper, instantiated twice (X and Y):
  - Parameters: BITS, MAX, HOME_VAL, REPEAT_DELAY, REPEAT_RATE, WRAP.
  - Owns its FSM, timer and position register.
  - Outputs position and step_done.
- Top level: OR-combines step_done into moved; computes atEdge; holds the optional synchronisers.

Test Plan:
- Reset release, then stick idle 20 cycles → pixelX=0, pixelY=0, moved never 1.
- stickX=01 held 20 cycles (D=8, R=4, WRAP=0, start 0) → pixelX steps at edges 0, 8, 12, 16 → values 1, 2, 3, 4; moved pulses exactly 4 times.
- WRAP=0, X_MAX=5, stickX=01 held from X=5 → pixelX stays 5, no moved, atEdge=1. WRAP=1 same stimulus → pixelX=0 at edge 0.
- stickX=01 for 3 cycles, then 10 → pixelX 0→1 then back to 0 at the reversal edge; next repeat 8 cycles later (WRAP=1 → 5).
- stickY=11 held 30 cycles → no change. HOME pulse while pixelX=3/pixelY=2 with stick held → home position loaded, held stick steps on the edge after HOME falls.
- RST asserted mid-DELAY → pixel outputs return to home immediately (asynchronous); after release with stick held, first step occurs on the first edge.
